// File: rtl/card_code_receiver.sv
// card_code_receiver: deserialises reader frames (header nibble, code nibble,
// optional even-parity bit), enforces an inter-bit timeout, and emits a
// one-cycle accept or reject strobe with a saturating reject counter.
// Optional feature macro: CARD_PARITY_EN (adds a 9th even-parity bit).
module card_code_receiver #(
    parameter logic [3:0]  HEADER  = 4'hA,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rset,
    input  logic       card_bit,
    input  logic       card_bit_valid,
    input  logic       door_busy,
    output logic       validate_code,
    output logic [3:0] access_code,
    output logic       frame_error,
    output logic [2:0] err_code,
    output logic       rx_busy,
    output logic [7:0] reject_cnt
);

`ifdef CARD_PARITY_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif

    localparam logic [3:0] LAST_CNT = 4'(FRAME_LEN);
    localparam logic [7:0] GAP_MAX  = 8'(TIMEOUT);

    localparam logic [2:0] ERR_HEADER  = 3'd1;
    localparam logic [2:0] ERR_PARITY  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_DOOR    = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [FRAME_LEN-1:0] shreg, shreg_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [7:0]           gap_cnt, gap_cnt_n;
    logic                 validate_n;
    logic                 error_n;
    logic [2:0]           err_n;
    logic [3:0]           access_n;

    logic [3:0]           rx_header;
    logic [3:0]           rx_code;
    logic                 parity_bad;

    assign rx_header = shreg[FRAME_LEN-1 -: 4];
    assign rx_code   = shreg[FRAME_LEN-5 -: 4];

`ifdef CARD_PARITY_EN
    // Even parity over all nine received bits.
    assign parity_bad = ^shreg;
`else
    assign parity_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        gap_cnt_n  = gap_cnt;
        validate_n = 1'b0;
        error_n    = 1'b0;
        err_n      = '0;
        access_n   = access_code;

        case (state)
            IDLE: begin
                if (card_bit_valid) begin
                    shreg_n   = {{(FRAME_LEN-1){1'b0}}, card_bit};
                    bit_cnt_n = 4'd1;
                    gap_cnt_n = '0;
                    state_n   = RECV;
                end
            end
            RECV: begin
                if (card_bit_valid) begin
                    shreg_n   = {shreg[FRAME_LEN-2:0], card_bit};
                    bit_cnt_n = bit_cnt + 4'd1;
                    gap_cnt_n = '0;
                    if (bit_cnt + 4'd1 == LAST_CNT) begin
                        state_n = DONE;
                    end
                end else if (gap_cnt == GAP_MAX) begin
                    error_n   = 1'b1;
                    err_n     = ERR_TIMEOUT;
                    shreg_n   = '0;
                    bit_cnt_n = '0;
                    gap_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 8'd1;
                end
            end
            DONE: begin
                shreg_n   = '0;
                bit_cnt_n = '0;
                gap_cnt_n = '0;
                state_n   = IDLE;
                if (rx_header != HEADER) begin
                    error_n = 1'b1;
                    err_n   = ERR_HEADER;
                end else if (parity_bad) begin
                    error_n = 1'b1;
                    err_n   = ERR_PARITY;
                end else if (door_busy) begin
                    error_n = 1'b1;
                    err_n   = ERR_DOOR;
                end else begin
                    validate_n = 1'b1;
                    access_n   = rx_code;
                end
            end
            default: begin
                shreg_n   = '0;
                bit_cnt_n = '0;
                gap_cnt_n = '0;
                state_n   = IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            shreg         <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            validate_code <= 1'b0;
            access_code   <= '0;
            frame_error   <= 1'b0;
            err_code      <= '0;
            rx_busy       <= 1'b0;
            reject_cnt    <= '0;
        end else begin
            shreg         <= shreg_n;
            bit_cnt       <= bit_cnt_n;
            gap_cnt       <= gap_cnt_n;
            validate_code <= validate_n;
            access_code   <= access_n;
            frame_error   <= error_n;
            err_code      <= err_n;
            rx_busy       <= (state_n == RECV) || (state_n == DONE);
            if (error_n && (reject_cnt != 8'hFF)) begin
                reject_cnt <= reject_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_card_code_receiver.sv
// Directed bench for card_code_receiver; frame length follows CARD_PARITY_EN.
module tb_card_code_receiver;

`ifdef CARD_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam int TMO = 16;

    logic       clk;
    logic       rset;
    logic       card_bit;
    logic       card_bit_valid;
    logic       door_busy;
    logic       validate_code;
    logic [3:0] access_code;
    logic       frame_error;
    logic [2:0] err_code;
    logic       rx_busy;
    logic [7:0] reject_cnt;

    int total;
    int bad;

    card_code_receiver #(
        .HEADER  (4'hA),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rset           (rset),
        .card_bit       (card_bit),
        .card_bit_valid (card_bit_valid),
        .door_busy      (door_busy),
        .validate_code  (validate_code),
        .access_code    (access_code),
        .frame_error    (frame_error),
        .err_code       (err_code),
        .rx_busy        (rx_busy),
        .reject_cnt     (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bits, right-aligned, first-sent bit highest.
    function automatic logic [8:0] mk(input logic [3:0] h, input logic [3:0] c);
`ifdef CARD_PARITY_EN
        return {h, c, ^{h, c}};
`else
        return {1'b0, h, c};
`endif
    endfunction

    task automatic send_bits(input logic [8:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            card_bit       = v[i];
            card_bit_valid = 1'b1;
            tick();
        end
        card_bit_valid = 1'b0;
        card_bit       = 1'b0;
    endtask

    task automatic expect_accept(input string tag, input logic [3:0] code, input int rej);
        tick();
        chk({tag, "_val"}, validate_code, 1'b1);
        chk({tag, "_fe"}, frame_error, 1'b0);
        chk({tag, "_acc"}, access_code, code);
        chk({tag, "_err"}, err_code, 3'd0);
        chk({tag, "_rej"}, reject_cnt, rej);
        chk({tag, "_busy"}, rx_busy, 1'b0);
        tick();
        chk({tag, "_val_end"}, validate_code, 1'b0);
    endtask

    task automatic expect_reject(input string tag, input logic [2:0] err,
                                 input logic [3:0] acc, input int rej);
        tick();
        chk({tag, "_fe"}, frame_error, 1'b1);
        chk({tag, "_err"}, err_code, err);
        chk({tag, "_val"}, validate_code, 1'b0);
        chk({tag, "_acc"}, access_code, acc);
        chk({tag, "_rej"}, reject_cnt, rej);
        tick();
        chk({tag, "_fe_end"}, frame_error, 1'b0);
        chk({tag, "_err_end"}, err_code, 3'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] v;
        int rej;
        total          = 0;
        bad            = 0;
        rej            = 0;
        rset           = 1'b0;
        card_bit       = 1'b0;
        card_bit_valid = 1'b0;
        door_busy      = 1'b0;

        // Reset values.
        tick();
        tick();
        chk("rst_val", validate_code, 1'b0);
        chk("rst_acc", access_code, 4'h0);
        chk("rst_fe", frame_error, 1'b0);
        chk("rst_err", err_code, 3'd0);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_rej", reject_cnt, 8'd0);
        rset = 1'b1;
        tick();

        // Good frame A/7, back-to-back bits.
        send_bits(mk(4'hA, 4'h7), FL);
        chk("good_busy_done", rx_busy, 1'b1);
        chk("good_val_early", validate_code, 1'b0);
        expect_accept("good", 4'h7, rej);

        // Header mismatch.
        send_bits(mk(4'hB, 4'h5), FL);
        rej++;
        expect_reject("hdr", 3'd1, 4'h7, rej);

`ifdef CARD_PARITY_EN
        // Odd ones count across nine bits.
        send_bits(9'b1010_0101_1, FL);
        rej++;
        expect_reject("par", 3'd2, 4'h7, rej);
        send_bits(9'b1010_0101_0, FL);
        expect_accept("par_ok", 4'h5, rej);
`else
        send_bits(mk(4'hA, 4'h5), FL);
        expect_accept("code5", 4'h5, rej);
`endif

        // Door open only during reception is ignored.
        door_busy = 1'b1;
        send_bits(mk(4'hA, 4'hC), FL);
        door_busy = 1'b0;
        expect_accept("door_rx", 4'hC, rej);

        // Door open while in DONE rejects.
        send_bits(mk(4'hA, 4'h3), FL);
        door_busy = 1'b1;
        rej++;
        expect_reject("door", 3'd4, 4'hC, rej);
        door_busy = 1'b0;

        // A gap of exactly TIMEOUT idle cycles is still tolerated.
        v = mk(4'hA, 4'h6);
        send_bits(v >> (FL - 4), 4);
        repeat (TMO) tick();
        chk("gap_busy", rx_busy, 1'b1);
        chk("gap_fe", frame_error, 1'b0);
        send_bits(v, FL - 4);
        expect_accept("gap", 4'h6, rej);

        // Timeout: 3 bits then silence; error one edge after gap_cnt hits TIMEOUT.
        send_bits(9'b101, 3);
        repeat (TMO) tick();
        chk("tmo_fe_early", frame_error, 1'b0);
        chk("tmo_busy_early", rx_busy, 1'b1);
        tick();
        rej++;
        chk("tmo_fe", frame_error, 1'b1);
        chk("tmo_err", err_code, 3'd3);
        chk("tmo_val", validate_code, 1'b0);
        chk("tmo_busy", rx_busy, 1'b0);
        chk("tmo_rej", reject_cnt, rej);
        chk("tmo_acc", access_code, 4'h6);
        tick();
        chk("tmo_fe_end", frame_error, 1'b0);

        // Reset mid-frame.
        send_bits(mk(4'hA, 4'h1) >> (FL - 5), 5);
        rset = 1'b0;
        #1;
        chk("mrst_busy", rx_busy, 1'b0);
        chk("mrst_acc", access_code, 4'h0);
        chk("mrst_rej", reject_cnt, 8'd0);
        tick();
        chk("mrst_fe", frame_error, 1'b0);
        chk("mrst_val", validate_code, 1'b0);
        rset = 1'b1;
        rej  = 0;
        tick();
        chk("mrst_idle_fe", frame_error, 1'b0);
        send_bits(mk(4'hA, 4'h9), FL);
        expect_accept("post_rst", 4'h9, rej);

        // Saturation over 260 header errors.
        for (int f = 0; f < 260; f++) begin
            send_bits(mk(4'h5, 4'h0), FL);
            tick();
            if (f == 253) chk("sat_254", reject_cnt, 8'd254);
            if (f == 254) chk("sat_255", reject_cnt, 8'd255);
            if (f == 259) begin
                chk("sat_fe", frame_error, 1'b1);
                chk("sat_hold", reject_cnt, 8'd255);
            end
            tick();
        end
        chk("sat_final", reject_cnt, 8'd255);
        chk("sat_acc", access_code, 4'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
